// File: rtl/cla_topic_buf_arb_if.sv
// Requester and free-list handshake bundle for cla_topic_buf_arb.
// slave = arbiter side, master = requesters plus free list.
`ifndef TOPIC_VALUE_DEPTH_NBITS
`define TOPIC_VALUE_DEPTH_NBITS 4
`endif

interface cla_topic_buf_arb_if #(
  parameter int NREQ       = 4,
  parameter int BPTR_NBITS = `TOPIC_VALUE_DEPTH_NBITS
);
  logic [NREQ-1:0]            alloc_req;
  logic [NREQ-1:0]            alloc_gnt;
  logic [BPTR_NBITS-1:0]      alloc_ptr;
  logic [NREQ-1:0]            rel_req;
  logic [NREQ*BPTR_NBITS-1:0] rel_ptr;
  logic [NREQ-1:0]            rel_ack;
  logic                       freeb_init;
  logic                       freeb_init_done;
  logic                       freeb_empty;
  logic                       free_buf_rd;
  logic [BPTR_NBITS-1:0]      free_buf_ptr;
  logic                       rel_buf_valid;
  logic [BPTR_NBITS-1:0]      rel_buf_ptr;

  modport slave (
    input  alloc_req, rel_req, rel_ptr, freeb_init_done, freeb_empty, free_buf_ptr,
    output alloc_gnt, alloc_ptr, rel_ack, freeb_init, free_buf_rd, rel_buf_valid, rel_buf_ptr
  );

  modport master (
    output alloc_req, rel_req, rel_ptr, freeb_init_done, freeb_empty, free_buf_ptr,
    input  alloc_gnt, alloc_ptr, rel_ack, freeb_init, free_buf_rd, rel_buf_valid, rel_buf_ptr
  );
endinterface

// File: rtl/cla_topic_buf_arb.sv
// Round-robin alloc/release arbiter in front of a shared topic-value free list.
// Optional in-use counter and error flag: define CLA_TOPIC_BUF_ARB_STATS_EN.
`ifndef TOPIC_VALUE_DEPTH_NBITS
`define TOPIC_VALUE_DEPTH_NBITS 4
`endif

module cla_topic_buf_arb #(
  parameter int BPTR_NBITS = `TOPIC_VALUE_DEPTH_NBITS,
  parameter int NREQ       = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sw_reinit_i,
  cla_topic_buf_arb_if.slave    bus,
  output logic                  arb_ready_o,
  output logic [BPTR_NBITS:0]   inuse_count_o,
  output logic                  inuse_err_o
);
  localparam int RRW = $clog2(NREQ);

  typedef enum logic [1:0] {
    ST_WAIT_INIT = 2'd0,
    ST_RUN       = 2'd1,
    ST_REINIT    = 2'd2,
    ST_WAIT_DROP = 2'd3
  } state_e;

  function automatic logic [RRW-1:0] rr_pick(input logic [NREQ-1:0] elig,
                                             input logic [RRW-1:0]  start);
    logic [RRW-1:0] win;
    logic           found;
    int             idx;
    win   = start;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(start) + k) % NREQ;
      if (!found && elig[idx]) begin
        win   = RRW'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [RRW-1:0] rr_next(input logic [RRW-1:0] w);
    if (w == RRW'(NREQ - 1)) return '0;
    else                     return w + RRW'(1);
  endfunction

  state_e                state_q, state_d;
  logic                  freeb_init_q, freeb_init_d;
  logic                  arb_ready_q, arb_ready_d;
  logic [NREQ-1:0]       alloc_gnt_q, alloc_gnt_d;
  logic [BPTR_NBITS-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [RRW-1:0]        alloc_rr_q, alloc_rr_d;
  logic [NREQ-1:0]       rel_ack_q, rel_ack_d;
  logic                  rel_buf_valid_q, rel_buf_valid_d;
  logic [BPTR_NBITS-1:0] rel_buf_ptr_q, rel_buf_ptr_d;
  logic [RRW-1:0]        rel_rr_q, rel_rr_d;

  logic                  run_s;
  logic [NREQ-1:0]       alloc_elig_s, rel_elig_s;
  logic [RRW-1:0]        alloc_win_s, rel_win_s;
  logic                  pop_s, rel_fire_s;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_INIT: if (bus.freeb_init_done) state_d = ST_RUN;
                    else                     state_d = ST_WAIT_INIT;
      ST_RUN:       if (sw_reinit_i)         state_d = ST_REINIT;
                    else                     state_d = ST_RUN;
      ST_REINIT:                             state_d = ST_WAIT_DROP;
      ST_WAIT_DROP: if (!bus.freeb_init_done) state_d = ST_WAIT_INIT;
                    else                      state_d = ST_WAIT_DROP;
      default:                               state_d = ST_WAIT_INIT;
    endcase
  end

  // Status outputs are registered from the next state so they track state_q exactly.
  always_comb begin
    freeb_init_d = (state_d == ST_REINIT);
    arb_ready_d  = (state_d == ST_RUN);
  end

  // The grant/ack mask keeps a requester from being served while its pulse is visible.
  assign run_s        = (state_q == ST_RUN);
  assign alloc_elig_s = bus.alloc_req & ~alloc_gnt_q;
  assign rel_elig_s   = bus.rel_req & ~rel_ack_q;
  assign alloc_win_s  = rr_pick(alloc_elig_s, alloc_rr_q);
  assign rel_win_s    = rr_pick(rel_elig_s, rel_rr_q);
  assign pop_s        = run_s && (|alloc_elig_s) && !bus.freeb_empty && bus.freeb_init_done;
  assign rel_fire_s   = run_s && (|rel_elig_s);

  always_comb begin
    alloc_gnt_d     = '0;
    alloc_ptr_d     = '0;
    alloc_rr_d      = alloc_rr_q;
    rel_ack_d       = '0;
    rel_buf_valid_d = 1'b0;
    rel_buf_ptr_d   = '0;
    rel_rr_d        = rel_rr_q;
    if (pop_s) begin
      alloc_gnt_d = {{(NREQ-1){1'b0}}, 1'b1} << alloc_win_s;
      alloc_ptr_d = bus.free_buf_ptr;
      alloc_rr_d  = rr_next(alloc_win_s);
    end else begin
      alloc_rr_d  = alloc_rr_q;
    end
    if (rel_fire_s) begin
      rel_ack_d       = {{(NREQ-1){1'b0}}, 1'b1} << rel_win_s;
      rel_buf_valid_d = 1'b1;
      rel_buf_ptr_d   = bus.rel_ptr[rel_win_s*BPTR_NBITS +: BPTR_NBITS];
      rel_rr_d        = rr_next(rel_win_s);
    end else begin
      rel_rr_d        = rel_rr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ST_WAIT_INIT;
      freeb_init_q    <= 1'b0;
      arb_ready_q     <= 1'b0;
      alloc_gnt_q     <= '0;
      alloc_ptr_q     <= '0;
      alloc_rr_q      <= '0;
      rel_ack_q       <= '0;
      rel_buf_valid_q <= 1'b0;
      rel_buf_ptr_q   <= '0;
      rel_rr_q        <= '0;
    end else begin
      state_q         <= state_d;
      freeb_init_q    <= freeb_init_d;
      arb_ready_q     <= arb_ready_d;
      alloc_gnt_q     <= alloc_gnt_d;
      alloc_ptr_q     <= alloc_ptr_d;
      alloc_rr_q      <= alloc_rr_d;
      rel_ack_q       <= rel_ack_d;
      rel_buf_valid_q <= rel_buf_valid_d;
      rel_buf_ptr_q   <= rel_buf_ptr_d;
      rel_rr_q        <= rel_rr_d;
    end
  end

  assign bus.free_buf_rd   = pop_s;
  assign bus.alloc_gnt     = alloc_gnt_q;
  assign bus.alloc_ptr     = alloc_ptr_q;
  assign bus.rel_ack       = rel_ack_q;
  assign bus.rel_buf_valid = rel_buf_valid_q;
  assign bus.rel_buf_ptr   = rel_buf_ptr_q;
  assign bus.freeb_init    = freeb_init_q;
  assign arb_ready_o       = arb_ready_q;

`ifdef CLA_TOPIC_BUF_ARB_STATS_EN
  localparam logic [BPTR_NBITS:0] CNT_MAX = {1'b1, {BPTR_NBITS{1'b0}}};
  localparam logic [BPTR_NBITS:0] CNT_ONE = {{BPTR_NBITS{1'b0}}, 1'b1};

  logic [BPTR_NBITS:0] inuse_count_q, inuse_count_d;
  logic                inuse_err_q, inuse_err_d;

  // Pop and release in the same cycle cancel; out-of-range moves saturate and flag.
  always_comb begin
    inuse_count_d = inuse_count_q;
    inuse_err_d   = inuse_err_q;
    if (state_q == ST_REINIT) begin
      inuse_count_d = '0;
      inuse_err_d   = 1'b0;
    end else if (pop_s && !rel_fire_s) begin
      if (inuse_count_q == CNT_MAX) inuse_err_d   = 1'b1;
      else                          inuse_count_d = inuse_count_q + CNT_ONE;
    end else if (rel_fire_s && !pop_s) begin
      if (inuse_count_q == '0)      inuse_err_d   = 1'b1;
      else                          inuse_count_d = inuse_count_q - CNT_ONE;
    end else begin
      inuse_count_d = inuse_count_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inuse_count_q <= '0;
      inuse_err_q   <= 1'b0;
    end else begin
      inuse_count_q <= inuse_count_d;
      inuse_err_q   <= inuse_err_d;
    end
  end

  assign inuse_count_o = inuse_count_q;
  assign inuse_err_o   = inuse_err_q;
`else
  assign inuse_count_o = '0;
  assign inuse_err_o   = 1'b0;
`endif
endmodule

// File: tb/tb_cla_topic_buf_arb.sv
// Bench for cla_topic_buf_arb: directed tables, hand sequences and a random phase
// against a cycle reference model plus a small free-list emulation.
module tb_cla_topic_buf_arb;
  localparam int NREQ  = 4;
  localparam int B     = 4;
  localparam int DEPTH = 16;
  localparam int S_WAIT = 0, S_RUN = 1, S_REINIT = 2, S_DROP = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw  = 1'b0;
  logic       arb_ready;
  logic [B:0] inuse_count;
  logic       inuse_err;

  cla_topic_buf_arb_if #(.NREQ(NREQ), .BPTR_NBITS(B)) bus();

  cla_topic_buf_arb #(.BPTR_NBITS(B), .NREQ(NREQ)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .sw_reinit_i   (sw),
    .bus           (bus),
    .arb_ready_o   (arb_ready),
    .inuse_count_o (inuse_count),
    .inuse_err_o   (inuse_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Free-list emulation: FIFO of pointers, refilled with 0..DEPTH-1 on reset or init.
  logic [B-1:0] fl_mem [DEPTH];
  int           fl_head = 0;
  int           fl_cnt  = 0;
  logic         force_empty = 1'b0;
  logic         fl_pop, fl_push;

  assign bus.freeb_empty  = force_empty | (fl_cnt == 0);
  assign bus.free_buf_ptr = fl_mem[fl_head];
  assign fl_pop  = bus.free_buf_rd && (fl_cnt > 0);
  assign fl_push = bus.rel_buf_valid && ((fl_cnt < DEPTH) || fl_pop);

  always @(posedge clk) begin
    if (rst || bus.freeb_init) begin
      for (int i = 0; i < DEPTH; i++) fl_mem[i] <= B'(i);
      fl_head <= 0;
      fl_cnt  <= DEPTH;
    end else begin
      if (fl_push) fl_mem[(fl_head + fl_cnt) % DEPTH] <= bus.rel_buf_ptr;
      fl_head <= fl_pop ? (fl_head + 1) % DEPTH : fl_head;
      fl_cnt  <= fl_cnt - (fl_pop ? 1 : 0) + (fl_push ? 1 : 0);
    end
  end

  // Reference model: expected values of the registered outputs.
  int              m_state = S_WAIT;
  logic [NREQ-1:0] m_gnt = '0, m_ack = '0;
  logic [B-1:0]    m_ptr = '0, m_rptr = '0;
  logic            m_rvalid = 1'b0, m_init = 1'b0, m_ready = 1'b0;
  int              m_arr = 0, m_rrr = 0;
  int              m_cnt = 0;
  logic            m_err = 1'b0;
  logic            rd_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_find(input logic [NREQ-1:0] e, input int start);
    for (int k = 0; k < NREQ; k++)
      if (e[(start + k) % NREQ]) return (start + k) % NREQ;
    return -1;
  endfunction

  task automatic compare_all();
    chk("alloc_gnt", 32'(bus.alloc_gnt), 32'(m_gnt));
    if (m_gnt != '0) chk("alloc_ptr", 32'(bus.alloc_ptr), 32'(m_ptr));
    chk("rel_ack", 32'(bus.rel_ack), 32'(m_ack));
    chk("rel_buf_valid", 32'(bus.rel_buf_valid), 32'(m_rvalid));
    if (m_rvalid) chk("rel_buf_ptr", 32'(bus.rel_buf_ptr), 32'(m_rptr));
    chk("freeb_init", 32'(bus.freeb_init), 32'(m_init));
    chk("arb_ready", 32'(arb_ready), 32'(m_ready));
    chk("inuse_count", 32'(inuse_count), 32'(m_cnt));
    chk("inuse_err", 32'(inuse_err), 32'(m_err));
  endtask

  // One clock: inputs are already driven; evaluate the rules, clock, then compare.
  task automatic step();
    logic [NREQ-1:0] ae, re;
    int aw, rw, nst;
    logic pop, rel;
    #1;
    rd_seen = bus.free_buf_rd;
    ae  = bus.alloc_req & ~m_gnt;
    re  = bus.rel_req & ~m_ack;
    aw  = rr_find(ae, m_arr);
    rw  = rr_find(re, m_rrr);
    pop = (m_state == S_RUN) && (aw >= 0) && !bus.freeb_empty && bus.freeb_init_done;
    rel = (m_state == S_RUN) && (rw >= 0);
    if (rst) begin
      m_state = S_WAIT; m_gnt = '0; m_ack = '0; m_ptr = '0; m_rptr = '0;
      m_rvalid = 1'b0; m_init = 1'b0; m_ready = 1'b0;
      m_arr = 0; m_rrr = 0; m_cnt = 0; m_err = 1'b0;
    end else begin
      chk("free_buf_rd", 32'(rd_seen), 32'(pop));
`ifdef CLA_TOPIC_BUF_ARB_STATS_EN
      if (m_state == S_REINIT) begin
        m_cnt = 0; m_err = 1'b0;
      end else if (pop && !rel) begin
        if (m_cnt == DEPTH) m_err = 1'b1; else m_cnt = m_cnt + 1;
      end else if (rel && !pop) begin
        if (m_cnt == 0) m_err = 1'b1; else m_cnt = m_cnt - 1;
      end
`endif
      case (m_state)
        S_WAIT:   nst = bus.freeb_init_done ? S_RUN : S_WAIT;
        S_RUN:    nst = sw ? S_REINIT : S_RUN;
        S_REINIT: nst = S_DROP;
        default:  nst = bus.freeb_init_done ? S_DROP : S_WAIT;
      endcase
      m_state = nst;
      m_ready = (nst == S_RUN);
      m_init  = (nst == S_REINIT);
      m_gnt = '0;
      if (pop) begin
        m_gnt[aw] = 1'b1;
        m_ptr = bus.free_buf_ptr;
        m_arr = (aw + 1) % NREQ;
      end
      m_ack = '0;
      m_rvalid = rel;
      if (rel) begin
        m_ack[rw] = 1'b1;
        m_rptr = bus.rel_ptr[rw*B +: B];
        m_rrr = (rw + 1) % NREQ;
      end
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  typedef struct {
    logic [3:0] exp_gnt;
    logic [3:0] exp_ptr;
  } fair_vec_t;

  typedef struct {
    logic [3:0] areq;
    logic [3:0] rreq;
    logic [3:0] rp1;
    logic [3:0] rp3;
    logic       fe;
    logic       exp_rd;
    logic [3:0] exp_gnt;
    logic [3:0] exp_ptr;
    logic [3:0] exp_ack;
    logic       exp_rv;
    logic [3:0] exp_rptr;
  } rel_vec_t;

  fair_vec_t fair [16];
  rel_vec_t  rvec [8];
  int        drop_cnt;

  initial begin
    for (int i = 0; i < 16; i++) begin
      fair[i].exp_gnt = 4'b0001 << (i % 4);
      fair[i].exp_ptr = 4'(i);
    end
    //         areq     rreq     rp1    rp3    fe    rd    gnt      ptr    ack      rv    rptr
    rvec[0] = '{4'b0100, 4'b0000, 4'd5, 4'd9, 1'b1, 1'b0, 4'b0000, 4'd0, 4'b0000, 1'b0, 4'd0};
    rvec[1] = '{4'b0100, 4'b0000, 4'd5, 4'd9, 1'b1, 1'b0, 4'b0000, 4'd0, 4'b0000, 1'b0, 4'd0};
    rvec[2] = '{4'b0100, 4'b1010, 4'd5, 4'd9, 1'b1, 1'b0, 4'b0000, 4'd0, 4'b0010, 1'b1, 4'd5};
    rvec[3] = '{4'b0100, 4'b1010, 4'd5, 4'd9, 1'b1, 1'b0, 4'b0000, 4'd0, 4'b1000, 1'b1, 4'd9};
    rvec[4] = '{4'b0100, 4'b0000, 4'd5, 4'd9, 1'b0, 1'b1, 4'b0100, 4'd5, 4'b0000, 1'b0, 4'd0};
    rvec[5] = '{4'b0000, 4'b0000, 4'd5, 4'd9, 1'b0, 1'b0, 4'b0000, 4'd0, 4'b0000, 1'b0, 4'd0};
    rvec[6] = '{4'b0001, 4'b0010, 4'd7, 4'd9, 1'b0, 1'b1, 4'b0001, 4'd9, 4'b0010, 1'b1, 4'd7};
    rvec[7] = '{4'b0000, 4'b0000, 4'd7, 4'd9, 1'b0, 1'b0, 4'b0000, 4'd0, 4'b0000, 1'b0, 4'd0};

    bus.alloc_req = '0;
    bus.rel_req = '0;
    bus.rel_ptr = '0;
    bus.freeb_init_done = 1'b0;
    @(negedge clk);
    step();
    step();
    chk("rst_gnt", 32'(bus.alloc_gnt), 32'(0));
    chk("rst_ack", 32'(bus.rel_ack), 32'(0));
    chk("rst_rvalid", 32'(bus.rel_buf_valid), 32'(0));
    chk("rst_init", 32'(bus.freeb_init), 32'(0));
    chk("rst_ready", 32'(arb_ready), 32'(0));
    chk("rst_count", 32'(inuse_count), 32'(0));

    // Init wait with every requester asking.
    rst = 1'b0;
    bus.alloc_req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("init_wait_rd", 32'(rd_seen), 32'(0));
      chk("init_wait_ready", 32'(arb_ready), 32'(0));
    end
    bus.freeb_init_done = 1'b1;
    step();
    chk("ready_rise", 32'(arb_ready), 32'(1));

    // Fairness: 16 grants drain the list in order 0,1,2,3 repeating.
    for (int i = 0; i < 16; i++) begin
      step();
      chk("fair_gnt", 32'(bus.alloc_gnt), 32'(fair[i].exp_gnt));
      chk("fair_ptr", 32'(bus.alloc_ptr), 32'(fair[i].exp_ptr));
    end

    // Empty list and release sequencing.
    for (int i = 0; i < 8; i++) begin
      bus.alloc_req = rvec[i].areq;
      bus.rel_req   = rvec[i].rreq;
      bus.rel_ptr   = {rvec[i].rp3, 4'hE, rvec[i].rp1, 4'hC};
      force_empty   = rvec[i].fe;
      step();
      chk("tbl_rd", 32'(rd_seen), 32'(rvec[i].exp_rd));
      chk("tbl_gnt", 32'(bus.alloc_gnt), 32'(rvec[i].exp_gnt));
      if (rvec[i].exp_gnt != 4'b0000) chk("tbl_ptr", 32'(bus.alloc_ptr), 32'(rvec[i].exp_ptr));
      chk("tbl_ack", 32'(bus.rel_ack), 32'(rvec[i].exp_ack));
      chk("tbl_rvalid", 32'(bus.rel_buf_valid), 32'(rvec[i].exp_rv));
      if (rvec[i].exp_rv) chk("tbl_rptr", 32'(bus.rel_buf_ptr), 32'(rvec[i].exp_rptr));
    end

    // Re-initialisation: one-cycle init pulse, traffic held until done falls and rises.
    sw = 1'b1;
    step();
    chk("reinit_pulse", 32'(bus.freeb_init), 32'(1));
    chk("reinit_ready", 32'(arb_ready), 32'(0));
    sw = 1'b0;
    bus.alloc_req = 4'b1111;
    bus.rel_req = 4'b0001;
    step();
    chk("reinit_pulse_end", 32'(bus.freeb_init), 32'(0));
    chk("reinit_count", 32'(inuse_count), 32'(0));
    for (int i = 0; i < 2; i++) begin
      step();
      chk("drop_gnt", 32'(bus.alloc_gnt), 32'(0));
      chk("drop_ack", 32'(bus.rel_ack), 32'(0));
    end
    bus.freeb_init_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("wait_gnt", 32'(bus.alloc_gnt), 32'(0));
      chk("wait_ack", 32'(bus.rel_ack), 32'(0));
    end
    bus.alloc_req = '0;
    bus.rel_req = '0;
    bus.freeb_init_done = 1'b1;
    step();
    chk("rerun_ready", 32'(arb_ready), 32'(1));

    // Counter: underflow flag, then 3 pops and one pop+release.
    bus.rel_req = 4'b0001;
    bus.rel_ptr = {4'd1, 4'd2, 4'd4, 4'd3};
    step();
    bus.rel_req = '0;
    step();
`ifdef CLA_TOPIC_BUF_ARB_STATS_EN
    chk("stats_err_sticky", 32'(inuse_err), 32'(1));
    chk("stats_count_zero", 32'(inuse_count), 32'(0));
`else
    chk("stats_err_tied", 32'(inuse_err), 32'(0));
    chk("stats_count_tied", 32'(inuse_count), 32'(0));
`endif
    bus.alloc_req = 4'b1111;
    for (int i = 0; i < 3; i++) step();
    bus.rel_req = 4'b0010;
    step();
`ifdef CLA_TOPIC_BUF_ARB_STATS_EN
    chk("stats_count3", 32'(inuse_count), 32'(3));
    chk("stats_err_still", 32'(inuse_err), 32'(1));
`else
    chk("stats_count3_tied", 32'(inuse_count), 32'(0));
`endif
    bus.alloc_req = '0;
    bus.rel_req = '0;
    step();

    // Random traffic with occasional re-init against the model.
    drop_cnt = 0;
    for (int i = 0; i < 500; i++) begin
      bus.alloc_req = 4'($urandom);
      bus.rel_req   = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      bus.rel_ptr   = 16'($urandom);
      force_empty   = ($urandom_range(0, 4) == 0);
      sw            = ($urandom_range(0, 59) == 0);
      if (m_init) drop_cnt = 3;
      if (drop_cnt > 0) begin
        bus.freeb_init_done = 1'b0;
        drop_cnt--;
      end else begin
        bus.freeb_init_done = 1'b1;
      end
      step();
    end
    sw = 1'b0;
    force_empty = 1'b0;
    bus.freeb_init_done = 1'b1;

    // Reset in the middle of traffic.
    for (int i = 0; i < 4; i++) step();
    bus.alloc_req = 4'b1111;
    bus.rel_req = 4'b1111;
    step();
    rst = 1'b1;
    step();
    chk("midrst_gnt", 32'(bus.alloc_gnt), 32'(0));
    chk("midrst_ack", 32'(bus.rel_ack), 32'(0));
    chk("midrst_rvalid", 32'(bus.rel_buf_valid), 32'(0));
    chk("midrst_ready", 32'(arb_ready), 32'(0));
    chk("midrst_err", 32'(inuse_err), 32'(0));
    rst = 1'b0;
    bus.alloc_req = '0;
    bus.rel_req = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cla_topic_buf_arb.md
Name: cla_topic_buf_arb

Overview:
- Shares one topic-value free list among NREQ requesters.
- Round-robin arbitrates allocation requests onto the free list pop port (free_buf_rd / free_buf_ptr).
- Round-robin arbitrates release requests onto the single push port (rel_buf_valid / rel_buf_ptr).
- Sequences free-list (re)initialisation and holds all traffic off until the list reports init done.

Parameters:
- BPTR_NBITS, `TOPIC_VALUE_DEPTH_NBITS: buffer pointer width; the free list holds 2**BPTR_NBITS entries.
- NREQ, 4: number of requesters, range 2..8.

Ports:
- clk  input  1  clock.
- `RESET_SIG  input  1  reset. One clock; reset is synchronous and active-high.
- sw_reinit  input  1  pulse; request re-initialisation of the free list.
- alloc_req  input  NREQ  level; requester i wants one pointer.
- alloc_gnt  output  NREQ  one-hot pulse; grant to requester i.
- alloc_ptr  output  BPTR_NBITS  pointer for the current alloc_gnt; valid only while alloc_gnt != 0.
- rel_req  input  NREQ  level; requester i releases the pointer on rel_ptr[i].
- rel_ptr  input  NREQ*BPTR_NBITS  packed release pointers; slice i is bits [i*BPTR_NBITS +: BPTR_NBITS].
- rel_ack  output  NREQ  one-hot pulse; release from requester i accepted.
- freeb_init  output  1  to free list; starts re-init.
- freeb_init_done  input  1  from free list.
- freeb_empty  input  1  from free list.
- free_buf_rd  output  1  to free list; combinational pop.
- free_buf_ptr  input  BPTR_NBITS  from free list; head pointer, valid while !freeb_empty.
- rel_buf_valid  output  1  to free list.
- rel_buf_ptr  output  BPTR_NBITS  to free list.
- arb_ready  output  1  state is RUN.
- inuse_count  output  BPTR_NBITS+1  pointers currently allocated (optional feature).
- inuse_err  output  1  sticky underflow/overflow flag (optional feature).

Behaviour:
- Reset values: every output is 0. State = WAIT_INIT. Both round-robin pointers = 0.

State machine:
- WAIT_INIT -> RUN when freeb_init_done = 1.
- RUN -> REINIT when sw_reinit = 1.
- REINIT: assert freeb_init (registered) for exactly 1 cycle, then go to WAIT_DROP.
- WAIT_DROP -> WAIT_INIT when freeb_init_done = 0.
- sw_reinit outside RUN is ignored.
- arb_ready = 1 only in RUN.
- No grants and no acks in any state other than RUN. Pending requests are held, not dropped.

Allocation:
- Cycle N, in RUN: eligible = alloc_req & ~alloc_gnt. The mask stops a requester from being re-granted while its grant is visible.
- If eligible != 0 and freeb_empty = 0 and freeb_init_done = 1:
  - pick a winner round-robin, searching from alloc_rr;
  - assert free_buf_rd combinationally in cycle N;
  - register free_buf_ptr into alloc_ptr;
  - alloc_gnt is one-hot in cycle N+1;
  - alloc_rr becomes winner+1, mod NREQ.
- At most one pop per cycle. free_buf_rd is never asserted while freeb_empty = 1.
- A requester holding alloc_req gets its next pointer no earlier than cycle N+2.

Release:
- Cycle N, in RUN: eligible = rel_req & ~rel_ack. Pick a winner round-robin from rel_rr.
- Cycle N+1: rel_buf_valid = 1, rel_buf_ptr = rel_ptr[winner] as sampled in N, rel_ack[winner] = 1.
- rel_rr becomes winner+1, mod NREQ.
- One release per cycle. Release has no backpressure, because the free list cannot overflow with legal use.

Simultaneity and mid-operation events:
- Allocation and release proceed in the same cycle independently.
- A grant or ack already registered when leaving RUN still completes in the next cycle.
- Reset mid-operation: all outputs return to 0 in the cycle after reset is sampled high. The free list must be reset or re-initialised in the same way.

Optional Feature:
CLA_TOPIC_BUF_ARB_STATS_EN:
- Defined:
  - inuse_count increments on each pop and decrements on each release accept; both in one cycle leaves it unchanged.
  - Release with count = 0: count stays 0, inuse_err set.
  - Pop with count = 2**BPTR_NBITS: count saturates, inuse_err set.
  - inuse_err is sticky until reset or REINIT. REINIT also clears the count.
- Undefined: inuse_count and inuse_err are tied to 0 and the counter logic is absent. Arbitration behaviour is identical.

Test Plan:
- Init wait: hold freeb_init_done = 0 for 10 cycles after reset with alloc_req = 4'b1111 -> no free_buf_rd, arb_ready = 0. Raise done -> arb_ready = 1 next cycle; grants to 0,1,2,3 in 4 consecutive-eligible cycles; alloc_ptr = head values 0,1,2,3.
- Fairness: alloc_req = 4'b1111 held for 16 grants -> each requester gets exactly 4 grants, order 0,1,2,3 repeating. No requester is granted in two adjacent cycles.
- Empty: freeb_empty = 1 with alloc_req = 4'b0100 -> free_buf_rd = 0 and no grant. Deassert empty -> grant to requester 2 one cycle after the pop.
- Release: rel_req = 4'b1010 with rel_ptr[1] = 5, rel_ptr[3] = 9 -> rel_buf_ptr = 5 then 9 on consecutive cycles, rel_ack = 0010 then 1000. Simultaneous alloc grant is unaffected.
- Reinit: sw_reinit in RUN -> freeb_init is a 1-cycle pulse. No grants or acks until freeb_init_done falls then rises. With STATS_EN, inuse_count = 0 after reinit.
- Stats (STATS_EN): release with inuse_count = 0 -> inuse_err = 1 and stays 1. 3 pops plus 1 simultaneous pop/release -> inuse_count = 3.
